zest_spi_master: RTL

ZEST_SPI_MASTER -- requirements
Module: zest_spi_master

---
 rtl/zest_spi_master.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/zest_spi_master.sv
// SPI / uWire master for the Zest board: LMK01801 (uWire), two AD9653 and one AD9781 on a shared bus.
// Optional readback path is enabled by defining ZEST_SPI_READBACK_EN.
module zest_spi_master #(
   parameter int HALF = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  target,
   input  logic        rw,
   input  logic [12:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rdata,
   output logic        sclk,
   output logic        sdi,
   input  logic        sdo,
   output logic        sdio_as_i,
   output logic        u1_le,
   output logic        u2_csb,
   output logic        u3_csb,
   output logic        u4_csb
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI, ST_HOLD, ST_LATCH, ST_GAP
   } state_t;

   localparam logic [8:0] HALF_LEN  = 9'(HALF);
   localparam logic [8:0] LATCH_LEN = 9'(2 * HALF);

   // Frame is left-aligned so the MSB is always bit 31; read data bits go out as zeros.
   function automatic logic [31:0] build_frame(input logic [1:0] tgt, input logic rd,
                                               input logic [12:0] a, input logic [31:0] wd);
      logic [7:0] d;
      d = rd ? 8'h00 : wd[7:0];
      case (tgt)
         2'd0:    build_frame = wd;
         2'd3:    build_frame = {rd, 2'b00, a[4:0], d, 16'h0000};
         default: build_frame = {rd, 2'b00, a, d, 8'h00};
      endcase
   endfunction

   function automatic logic [4:0] frame_last_bit(input logic [1:0] tgt);
      case (tgt)
         2'd0:    frame_last_bit = 5'd31;
         2'd3:    frame_last_bit = 5'd15;
         default: frame_last_bit = 5'd23;
      endcase
   endfunction

   state_t      state_r, state_nx_s;
   logic [8:0]  cnt_r, cnt_nx_s;
   logic [4:0]  bit_r, bit_nx_s;
   logic [4:0]  last_bit_r, last_bit_nx_s;
   logic [31:0] frame_r, frame_nx_s;
   logic [1:0]  tgt_r, tgt_nx_s;
   logic        rd_r, rd_nx_s;
   logic        rd_req_s;
   logic        last_s;

   logic busy_r, done_r, sclk_r, sdi_r, sdio_r, le_r, u2_csb_r, u3_csb_r, u4_csb_r;
   logic busy_nx_s, done_nx_s, sclk_nx_s, sdi_nx_s, sdio_nx_s, le_nx_s;
   logic u2_csb_nx_s, u3_csb_nx_s, u4_csb_nx_s;
   logic shifting_s, cs_active_s;

`ifdef ZEST_SPI_READBACK_EN
   assign rd_req_s = rw & (target != 2'd0);
`else
   logic unused_s;
   assign rd_req_s = 1'b0;
   assign unused_s = ^{rw, sdo};
`endif

   assign last_s = (cnt_r == (((state_r == ST_LATCH) ? LATCH_LEN : HALF_LEN) - 9'd1));

   // State and transaction context registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 9'd0;
         bit_r      <= 5'd0;
         last_bit_r <= 5'd0;
         frame_r    <= 32'h0000_0000;
         tgt_r      <= 2'd0;
         rd_r       <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         bit_r      <= bit_nx_s;
         last_bit_r <= last_bit_nx_s;
         frame_r    <= frame_nx_s;
         tgt_r      <= tgt_nx_s;
         rd_r       <= rd_nx_s;
      end
   end

   // Next-state logic; every state lasts HALF cycles except LATCH (2*HALF).
   always_comb begin
      state_nx_s    = state_r;
      cnt_nx_s      = last_s ? 9'd0 : cnt_r + 9'd1;
      bit_nx_s      = bit_r;
      last_bit_nx_s = last_bit_r;
      frame_nx_s    = frame_r;
      tgt_nx_s      = tgt_r;
      rd_nx_s       = rd_r;
      case (state_r)
         ST_IDLE: begin
            cnt_nx_s = 9'd0;
            if (start) begin
               state_nx_s    = ST_SETUP;
               bit_nx_s      = 5'd0;
               tgt_nx_s      = target;
               rd_nx_s       = rd_req_s;
               frame_nx_s    = build_frame(target, rd_req_s, addr, wdata);
               last_bit_nx_s = frame_last_bit(target);
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (last_s) state_nx_s = ST_SHIFT_LO;
            else        state_nx_s = ST_SETUP;
         end
         ST_SHIFT_LO: begin
            if (last_s) state_nx_s = ST_SHIFT_HI;
            else        state_nx_s = ST_SHIFT_LO;
         end
         ST_SHIFT_HI: begin
            if (last_s && (bit_r == last_bit_r)) begin
               state_nx_s = ST_HOLD;
            end else if (last_s) begin
               state_nx_s = ST_SHIFT_LO;
               bit_nx_s   = bit_r + 5'd1;
            end else begin
               state_nx_s = ST_SHIFT_HI;
            end
         end
         ST_HOLD: begin
            if (last_s) state_nx_s = (tgt_r == 2'd0) ? ST_LATCH : ST_GAP;
            else        state_nx_s = ST_HOLD;
         end
         ST_LATCH: begin
            if (last_s) state_nx_s = ST_GAP;
            else        state_nx_s = ST_LATCH;
         end
         ST_GAP: begin
            if (last_s) state_nx_s = ST_IDLE;
            else        state_nx_s = ST_GAP;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so that the registered pins line up with it.
   always_comb begin
      shifting_s  = (state_nx_s == ST_SETUP) || (state_nx_s == ST_SHIFT_LO) ||
                    (state_nx_s == ST_SHIFT_HI);
      cs_active_s = shifting_s || (state_nx_s == ST_HOLD);
      busy_nx_s   = (state_nx_s != ST_IDLE);
      done_nx_s   = (state_nx_s == ST_GAP) && (state_r != ST_GAP);
      sclk_nx_s   = (state_nx_s == ST_SHIFT_HI);
      sdi_nx_s    = shifting_s ? frame_nx_s[5'd31 - bit_nx_s] : 1'b0;
      sdio_nx_s   = rd_nx_s && cs_active_s && (state_nx_s != ST_SETUP) &&
                    (bit_nx_s >= (last_bit_nx_s - 5'd7));
      le_nx_s     = (state_nx_s == ST_LATCH);
      u2_csb_nx_s = !(cs_active_s && (tgt_nx_s == 2'd1));
      u3_csb_nx_s = !(cs_active_s && (tgt_nx_s == 2'd2));
      u4_csb_nx_s = !(cs_active_s && (tgt_nx_s == 2'd3));
   end

   // Registered bus and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         sclk_r   <= 1'b0;
         sdi_r    <= 1'b0;
         sdio_r   <= 1'b0;
         le_r     <= 1'b0;
         u2_csb_r <= 1'b1;
         u3_csb_r <= 1'b1;
         u4_csb_r <= 1'b1;
      end else begin
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
         sclk_r   <= sclk_nx_s;
         sdi_r    <= sdi_nx_s;
         sdio_r   <= sdio_nx_s;
         le_r     <= le_nx_s;
         u2_csb_r <= u2_csb_nx_s;
         u3_csb_r <= u3_csb_nx_s;
         u4_csb_r <= u4_csb_nx_s;
      end
   end

`ifdef ZEST_SPI_READBACK_EN
   logic [7:0] rx_r;
   logic [7:0] rdata_r;
   logic       sample_s;

   assign sample_s = (state_r == ST_SHIFT_HI) && last_s && rd_r &&
                     (bit_r >= (last_bit_r - 5'd7));

   // Capture sdo at the end of each data high phase; publish the byte with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_r    <= 8'h00;
         rdata_r <= 8'h00;
      end else begin
         if (sample_s) rx_r <= {rx_r[6:0], sdo};
         else          rx_r <= rx_r;
         if (done_nx_s && rd_r) rdata_r <= rx_r;
         else                   rdata_r <= rdata_r;
      end
   end

   assign rdata = rdata_r;
`else
   assign rdata = 8'h00;
`endif

   assign busy      = busy_r;
   assign done      = done_r;
   assign sclk      = sclk_r;
   assign sdi       = sdi_r;
   assign sdio_as_i = sdio_r;
   assign u1_le     = le_r;
   assign u2_csb    = u2_csb_r;
   assign u3_csb    = u3_csb_r;
   assign u4_csb    = u4_csb_r;

endmodule
